// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: forwarding, load-use stalls, branch flushes, data-memory wait sequencing.
// Optional performance counters are compiled in with `define HAZARD_PERF_EN.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             ResultSrcE,
  input  logic             PCsrcE,
  input  logic             MemReqM,
  input  logic             MemAckM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             Error,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_C = MEM_TIMEOUT[7:0];

  state_t     state;
  logic [7:0] wait_cnt;
  logic       lw_stall;
  logic       mem_stall;

  // M-stage results are newer than W-stage results, so they win
  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))
      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E))
      ForwardAE = 2'b01;
  end

  always_comb begin
    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))
      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E))
      ForwardBE = 2'b01;
  end

  assign lw_stall  = ResultSrcE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign mem_stall = MemReqM && !MemAckM;

  // A pending memory access freezes everything up to M; a branch held in E is replayed later
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    case (state)
      INIT: begin
        StallF = 1'b1;
        FlushD = 1'b1;
        FlushE = 1'b1;
      end
      RUN, MEM_WAIT: begin
        if ((state == RUN) ? mem_stall : !MemAckM) begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          StallM = 1'b1;
          FlushW = 1'b1;
        end else if (PCsrcE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (lw_stall) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
      default: begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end
    endcase
  end

  assign Error = (state == ERROR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      wait_cnt <= 8'd0;
    end else begin
      case (state)
        INIT: begin
          state    <= RUN;
          wait_cnt <= 8'd0;
        end
        RUN: begin
          if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (MemAckM) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == TIMEOUT_C) begin
            state    <= ERROR;
            wait_cnt <= 8'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state    <= ERROR;
          wait_cnt <= 8'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             count_en;

  assign count_en = (state == RUN) || (state == MEM_WAIT);

  // Saturating counters so a long run never wraps back to a misleading small value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (count_en && StallF && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (count_en && FlushE && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign StallCnt = stall_cnt;
  assign FlushCnt = flush_cnt;
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule
